// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: register file with write-back bypass, immediate
// extension, load-use hazard detection and an ID/EX register with stall and flush.
module decode_stage #(
    parameter  int DATA_W    = 32,
    parameter  int REG_COUNT = 32,
    parameter  int ZERO_REG  = 1,
    parameter  int LINK_REG  = 31,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_instruction,
    input  logic [DATA_W-1:0] if_pc_plus4,
    output logic              if_ready,
    input  logic              ctrl_reg_write,
    input  logic              ctrl_reg_dst,
    input  logic              ctrl_jal,
    input  logic              ctrl_mem_read,
    input  logic              ctrl_zero_ext,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_ready,
    input  logic              flush,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [AW-1:0]     ex_rs,
    output logic [AW-1:0]     ex_rt,
    output logic [AW-1:0]     ex_dst,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [15:0]       hazard_cnt
);

    // Read port: protected register 0 reads zero, a same-cycle write-back wins
    // over the stored value so the consumer never sees stale data.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [AW-1:0]     idx,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [AW-1:0]     wa,
        input logic [DATA_W-1:0] wd
    );
        if ((ZERO_REG != 0) && (idx == '0)) return '0;
        if (we && (wa == idx)) return wd;
        return stored;
    endfunction

    function automatic logic [DATA_W-1:0] extend_imm(
        input logic [15:0] imm,
        input logic        zext
    );
        logic signed [15:0]       imm_s;
        logic signed [DATA_W-1:0] imm_sx;
        imm_s  = imm;
        imm_sx = imm_s;
        return zext ? DATA_W'(imm) : imm_sx;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    // ---- decode (combinational, from IF/ID) ----
    logic [DATA_W-1:0] rf_q [REG_COUNT];

    logic [AW-1:0]     rs_idx;
    logic [AW-1:0]     rt_idx;
    logic [AW-1:0]     rd_idx;
    logic [AW-1:0]     dst_idx;
    logic [15:0]       imm_raw;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm_ext;
    logic              rf_we;
    logic              hazard;
    logic              unused_opcode;

    assign rs_idx        = if_instruction[21 +: AW];
    assign rt_idx        = if_instruction[16 +: AW];
    assign rd_idx        = if_instruction[11 +: AW];
    assign imm_raw       = if_instruction[15:0];
    assign unused_opcode = ^if_instruction[31:26];

    assign rf_we   = wb_en && !((ZERO_REG != 0) && (wb_addr == '0));
    assign rs_val  = read_port(rs_idx, rf_q[rs_idx], wb_en, wb_addr, wb_data);
    assign rt_val  = read_port(rt_idx, rf_q[rt_idx], wb_en, wb_addr, wb_data);
    assign imm_ext = extend_imm(imm_raw, ctrl_zero_ext);
    assign dst_idx = ctrl_jal ? AW'(LINK_REG) : (ctrl_reg_dst ? rd_idx : rt_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    // ---- hazard detection ----
    logic              ex_valid_q,     ex_valid_d;
    logic [DATA_W-1:0] ex_rs_data_q,   ex_rs_data_d;
    logic [DATA_W-1:0] ex_rt_data_q,   ex_rt_data_d;
    logic [DATA_W-1:0] ex_imm_q,       ex_imm_d;
    logic [AW-1:0]     ex_rs_q,        ex_rs_d;
    logic [AW-1:0]     ex_rt_q,        ex_rt_d;
    logic [AW-1:0]     ex_dst_q,       ex_dst_d;
    logic              ex_reg_write_q, ex_reg_write_d;
    logic              ex_mem_read_q,  ex_mem_read_d;
    logic [DATA_W-1:0] ex_pc_plus4_q,  ex_pc_plus4_d;
    logic [15:0]       hazard_cnt_q,   hazard_cnt_d;

    // A load to $0 never produces a value worth waiting for.
    assign hazard = ex_valid_q && ex_mem_read_q && (ex_dst_q != '0) &&
                    ((ex_dst_q == rs_idx) || (ex_dst_q == rt_idx)) && if_valid;

    assign if_ready = ex_ready && !hazard;

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_rs_data_d   = ex_rs_data_q;
        ex_rt_data_d   = ex_rt_data_q;
        ex_imm_d       = ex_imm_q;
        ex_rs_d        = ex_rs_q;
        ex_rt_d        = ex_rt_q;
        ex_dst_d       = ex_dst_q;
        ex_reg_write_d = ex_reg_write_q;
        ex_mem_read_d  = ex_mem_read_q;
        ex_pc_plus4_d  = ex_pc_plus4_q;

        // Flush outranks back-pressure; every bubble also drops its side effects.
        if (flush) begin
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
        end else if (ex_ready) begin
            if (hazard || !if_valid) begin
                ex_valid_d     = 1'b0;
                ex_reg_write_d = 1'b0;
                ex_mem_read_d  = 1'b0;
            end else begin
                ex_valid_d     = 1'b1;
                ex_rs_data_d   = rs_val;
                ex_rt_data_d   = rt_val;
                ex_imm_d       = imm_ext;
                ex_rs_d        = rs_idx;
                ex_rt_d        = rt_idx;
                ex_dst_d       = dst_idx;
                ex_reg_write_d = ctrl_reg_write || ctrl_jal;
                ex_mem_read_d  = ctrl_mem_read;
                ex_pc_plus4_d  = if_pc_plus4;
            end
        end

        hazard_cnt_d = (hazard && ex_ready) ? sat_inc(hazard_cnt_q) : hazard_cnt_q;
    end

    // ---- ID/EX register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_rs_data_q   <= '0;
            ex_rt_data_q   <= '0;
            ex_imm_q       <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_dst_q       <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_pc_plus4_q  <= '0;
            hazard_cnt_q   <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_rs_data_q   <= ex_rs_data_d;
            ex_rt_data_q   <= ex_rt_data_d;
            ex_imm_q       <= ex_imm_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_dst_q       <= ex_dst_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_pc_plus4_q  <= ex_pc_plus4_d;
            hazard_cnt_q   <= hazard_cnt_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_rs_data   = ex_rs_data_q;
    assign ex_rt_data   = ex_rt_data_q;
    assign ex_imm       = ex_imm_q;
    assign ex_rs        = ex_rs_q;
    assign ex_rt        = ex_rt_q;
    assign ex_dst       = ex_dst_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_pc_plus4  = ex_pc_plus4_q;
    assign hazard_cnt   = hazard_cnt_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined instruction-decode stage for the MIPS datapath, built as the successor to the single-cycle decoder. It contains a parametrised register file with write-through bypass from write-back and immediate extension, and sits between the IF/ID latch and the execute stage. It detects load-use hazards and stalls upstream, and holds decoded operands in an internal ID/EX pipeline register with back-pressure and flush. The controller remains a separate block; its control signals enter here alongside the instruction.

## Interface
- DATA_W, 32, register and operand width
- REG_COUNT, 32, number of architectural registers (power of two); AW = log2(REG_COUNT)
- ZERO_REG, 1, 1: register 0 reads as zero and ignores writes
- LINK_REG, 31, destination index used when ctrl_jal=1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_valid  in  1  IF/ID holds a valid instruction
- if_instruction  in  32  instruction word; rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0], low AW bits of each field used
- if_pc_plus4  in  DATA_W  PC+4 of that instruction
- if_ready  out  1  decode accepts the instruction this cycle
- ctrl_reg_write, ctrl_reg_dst, ctrl_jal, ctrl_mem_read, ctrl_zero_ext  in  1 each  controller outputs for if_instruction
- wb_en  in  1  write-back enable
- wb_addr  in  AW  write-back register
- wb_data  in  DATA_W  write-back data (link value already muxed by WB)
- ex_ready  in  1  execute stage accepts ID/EX contents
- flush  in  1  squash the instruction entering ID/EX (taken branch/jump)
- ex_valid  out  1  ID/EX holds a live instruction
- ex_rs_data, ex_rt_data  out  DATA_W  operands
- ex_imm  out  DATA_W  extended immediate
- ex_rs, ex_rt, ex_dst  out  AW  source and destination indices
- ex_reg_write, ex_mem_read  out  1  forwarded control
- ex_pc_plus4  out  DATA_W  forwarded PC+4
- hazard_cnt  out  16  saturating count of load-use stall cycles

## Operation
- Register file: REG_COUNT x DATA_W. Written on clk when wb_en=1, except index 0 when ZERO_REG=1.
- Reads are combinational from rs/rt. Bypass: if wb_en=1 and wb_addr equals the read index (and the index is not a ZERO_REG-protected 0), wb_data is returned instead of the stored value.
- Immediate: ctrl_zero_ext=1 gives {0, imm}; otherwise sign-extend imm[15] to DATA_W.
- Destination: ctrl_jal ? LINK_REG : (ctrl_reg_dst ? rd : rt).
- ex_reg_write = ctrl_reg_write | ctrl_jal.
- Load-use hazard (combinational): ex_valid & ex_mem_read & ex_dst≠0 & (ex_dst==rs | ex_dst==rt) & if_valid.
- if_ready = ex_ready & ~hazard.
- ID/EX update priority, evaluated each clk:
  1. flush → ex_valid←0; other fields don't-care.
  2. ~ex_ready → hold all fields.
  3. hazard → bubble: ex_valid←0, ex_reg_write←0, ex_mem_read←0.
  4. if_valid → load all decoded fields, ex_valid←1.
  5. Otherwise → bubble.
- Bubbles always have ex_reg_write=0 and ex_mem_read=0.
- hazard_cnt increments on every clk where hazard=1 and ex_ready=1. It saturates at 16'hFFFF.

## Timing
- Reset (async): all registers, all ex_* outputs and hazard_cnt go to 0; ex_valid=0. if_ready then equals ex_ready.
- Latency: instruction accepted at edge N appears on ex_* after edge N (1 cycle).
- A write and a read of the same register in the same cycle see the new data via the bypass; the array updates at the edge.
- Load-use stall: exactly 1 bubble cycle when ex_ready=1. The instruction is re-decoded the next cycle with hazard cleared.
- flush together with hazard or ~ex_ready: flush wins, and ex_valid=0 next cycle.
- rst asserted mid-stall: everything clears immediately, with no pending state retained.

## Test plan
- Reset, then write $5=0x1234 via WB. Decode "add $3,$5,$0" next cycle → ex_rs_data=0x1234, ex_rt_data=0, ex_dst=3 (reg_dst=1), ex_valid=1.
- Same-cycle bypass: wb_en=1, wb_addr=7, wb_data=0xCAFE while decoding rs=7 → ex_rs_data=0xCAFE after the edge.
- Write wb_addr=0 data 0xFFFF, then read $0 → 0 with ZERO_REG=1.
- Load "lw $8" in EX, "add $9,$8,$8" in ID → if_ready=0 for 1 cycle, one bubble, hazard_cnt=1, then add issues with ex_valid=1.
- ex_ready=0 for 3 cycles → ex_* stable and if_ready=0. Then flush=1 → ex_valid=0 next cycle.
- imm=0x8001: ctrl_zero_ext=0 → 0xFFFF8001; ctrl_zero_ext=1 → 0x00008001. ctrl_jal=1 → ex_dst=31, ex_reg_write=1.
